// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: ROM address/data, decoder control and head-of-queue outputs.
// The slave side is the queue itself; the master side is the ROM/decoder environment.
interface instr_fetch_queue_if #(
   parameter int D     = 12,
   parameter int W     = 9,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [D-1:0]  rom_addr;
   logic [W-1:0]  rom_data;
   logic          fetch_en;
   logic          consume;
   logic          redirect;
   logic [D-1:0]  redirect_target;
   logic          instr_valid;
   logic [W-1:0]  instr;
   logic [D-1:0]  instr_pc;
   logic [CW-1:0] count;

   modport slave (
      input  rom_data, fetch_en, consume, redirect, redirect_target,
      output rom_addr, instr_valid, instr, instr_pc, count
   );

   modport master (
      output rom_data, fetch_en, consume, redirect, redirect_target,
      input  rom_addr, instr_valid, instr, instr_pc, count
   );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch FIFO: fetches from a combinational ROM into a circular
// queue tagged with the fetch address; a taken branch flushes and reloads.
module instr_fetch_queue #(
   parameter int D     = 12,
   parameter int W     = 9,
   parameter int DEPTH = 4
) (
   input logic                 clk_i,
   input logic                 reset_i,
   instr_fetch_queue_if.slave  bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef struct packed {
      logic [W-1:0] code;
      logic [D-1:0] pc;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [D-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop, nonempty;

   assign nonempty = (count_q != '0);
   assign pop      = bus.consume & nonempty;
   // A full queue still accepts a fetch when the head retires the same cycle.
   assign push     = bus.fetch_en & ~bus.redirect & ((count_q < FULL_CNT) | pop);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (bus.redirect) begin
         fetch_pc_d = bus.redirect_target;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fetch_pc_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage is deliberately unreset; the head mask below hides stale contents.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {bus.rom_data, fetch_pc_q};
   end

   assign bus.rom_addr    = fetch_pc_q;
   assign bus.count       = count_q;
   assign bus.instr_valid = nonempty;
   assign bus.instr       = nonempty ? mem_q[rd_ptr_q].code : '0;
   assign bus.instr_pc    = nonempty ? mem_q[rd_ptr_q].pc   : '0;
endmodule
